// File: rtl/oam_dma_ctrl_if.sv
// CPU MMIO, DMA source-read and OAM write signals of the OAM DMA controller.
// CPU_BLOCK exists only when OAM_DMA_CPU_BLOCK_EN is defined.
interface oam_dma_ctrl_if;
    logic [15:0] ADDR;
    logic        WR;
    logic        RD;
    logic [7:0]  MMIO_DATA_out;
    logic [7:0]  MMIO_DATA_in;
    logic        DMA_RD;
    logic [15:0] DMA_ADDR;
    logic [7:0]  DMA_DATA_in;
    logic        OAM_WR;
    logic [15:0] OAM_ADDR;
    logic [7:0]  OAM_DATA;
    logic        DMA_ACTIVE;
`ifdef OAM_DMA_CPU_BLOCK_EN
    logic        CPU_BLOCK;
`endif

    modport slave (
`ifdef OAM_DMA_CPU_BLOCK_EN
        output CPU_BLOCK,
`endif
        input  ADDR, WR, RD, MMIO_DATA_out, DMA_DATA_in,
        output MMIO_DATA_in, DMA_RD, DMA_ADDR, OAM_WR, OAM_ADDR, OAM_DATA, DMA_ACTIVE
    );

    modport master (
`ifdef OAM_DMA_CPU_BLOCK_EN
        input  CPU_BLOCK,
`endif
        output ADDR, WR, RD, MMIO_DATA_out, DMA_DATA_in,
        input  MMIO_DATA_in, DMA_RD, DMA_ADDR, OAM_WR, OAM_ADDR, OAM_DATA, DMA_ACTIVE
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a write to FF46 copies 160 bytes from {src_hi,00} into FE00-FE9F.
// Optional macro OAM_DMA_CPU_BLOCK_EN adds CPU_BLOCK and blanks CPU reads while it is high.
module oam_dma_ctrl (
    input  logic          clk,
    input  logic          rst,
    oam_dma_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

    localparam logic [7:0] LAST_INDEX = 8'd159;

    state_t     state;
    state_t     state_next;
    logic [7:0] ff46;
    logic [7:0] src_hi;
    logic [7:0] index;
    logic       ff46_wr;
    logic       unused_rd;

    assign ff46_wr   = bus.WR && (bus.ADDR == 16'hFF46);
    // Reads have no side effect; RD is accepted only so the port is complete.
    assign unused_rd = bus.RD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff46 <= 8'h00;
        end else if (ff46_wr) begin
            ff46 <= bus.MMIO_DATA_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Source page is captured in START; E0-FF mirror onto C0-DF (echo RAM).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_hi <= 8'h00;
        end else if (state == START) begin
            src_hi <= (ff46 >= 8'hE0) ? (ff46 - 8'h20) : ff46;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index <= 8'h00;
        end else if (state == START) begin
            index <= 8'h00;
        end else if ((state == WRITE) && (index < LAST_INDEX)) begin
            index <= index + 8'd1;
        end
    end

    // A new FF46 write in READ/WRITE restarts; the WRITE-cycle OAM write still happens.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ff46_wr) state_next = START;
            START:   state_next = READ;
            READ:    state_next = ff46_wr ? START : WRITE;
            WRITE: begin
                if (ff46_wr) begin
                    state_next = START;
                end else if (index == LAST_INDEX) begin
                    state_next = IDLE;
                end else begin
                    state_next = READ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.DMA_RD     = 1'b0;
        bus.DMA_ADDR   = 16'h0000;
        bus.OAM_WR     = 1'b0;
        bus.OAM_ADDR   = 16'h0000;
        bus.OAM_DATA   = 8'h00;
        bus.DMA_ACTIVE = (state != IDLE);
        case (state)
            READ: begin
                bus.DMA_RD   = 1'b1;
                bus.DMA_ADDR = {src_hi, index};
            end
            WRITE: begin
                bus.OAM_WR   = 1'b1;
                bus.OAM_ADDR = 16'hFE00 + {8'h00, index};
                bus.OAM_DATA = bus.DMA_DATA_in;
            end
            default: ;
        endcase
    end

`ifdef OAM_DMA_CPU_BLOCK_EN
    // HRAM and FF46 itself remain reachable during a transfer.
    always_comb begin
        bus.CPU_BLOCK = (state != IDLE)
                        && !((bus.ADDR >= 16'hFF80) && (bus.ADDR <= 16'hFFFE))
                        && (bus.ADDR != 16'hFF46);
        if (bus.CPU_BLOCK) begin
            bus.MMIO_DATA_in = 8'hFF;
        end else if (bus.ADDR == 16'hFF46) begin
            bus.MMIO_DATA_in = ff46;
        end else begin
            bus.MMIO_DATA_in = 8'hFF;
        end
    end
`else
    always_comb begin
        bus.MMIO_DATA_in = (bus.ADDR == 16'hFF46) ? ff46 : 8'hFF;
    end
`endif

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: ADDR  input  16  CPU bus address.
REQ-004 SHALL have port: WR  input  1  CPU write strobe.
REQ-005 SHALL have port: RD  input  1  CPU read strobe.
REQ-006 SHALL have port: MMIO_DATA_out  input  8  CPU write data.
REQ-007 SHALL have port: MMIO_DATA_in  output  8  readback; FF46 value when ADDR==16'hFF46, else 8'hFF.
REQ-008 SHALL have port: DMA_RD  output  1  source read request.
REQ-009 SHALL have port: DMA_ADDR  output  16  source byte address.
REQ-010 SHALL have port: DMA_DATA_in  input  8  source read data, valid exactly one clk after DMA_RD.
REQ-011 SHALL have port: OAM_WR  output  1  OAM write strobe.
REQ-012 SHALL have port: OAM_ADDR  output  16  OAM destination, 16'hFE00-16'hFE9F.
REQ-013 SHALL have port: OAM_DATA  output  8  OAM write data.
REQ-014 SHALL have port: DMA_ACTIVE  output  1  high while a transfer occupies the OAM bus; PPU OAM scan and CPU OAM access yield.

Function
REQ-015 SHALL latch MMIO_DATA_out into FF46 on every cycle with WR && ADDR==16'hFF46; RD has no side effect.
REQ-016 SHALL use states IDLE, START, READ, WRITE; reset state IDLE.
REQ-017 SHALL go IDLE->START on an FF46 write; START lasts exactly 1 clk, clears index to 0, asserts DMA_ACTIVE, then goes to READ.
REQ-018 SHALL in READ drive DMA_RD=1 and DMA_ADDR={src_hi, index}, then go to WRITE.
REQ-019 SHALL in WRITE drive OAM_WR=1, OAM_ADDR=16'hFE00+index, OAM_DATA=DMA_DATA_in; DMA_RD=0.
REQ-020 SHALL from WRITE increment index and return to READ when index<159; at index==159 go to IDLE and deassert DMA_ACTIVE on the next clk.
REQ-021 SHALL transfer 160 bytes in 1+320 clk; DMA_ACTIVE high for exactly 321 consecutive cycles.
REQ-022 SHALL set src_hi = FF46-8'h20 when FF46>=8'hE0 (echo-RAM mirror), else FF46, sampled in START.
REQ-023 SHALL restart on an FF46 write in READ or WRITE: the pending OAM write in that cycle still completes, then next state is START with the new source, and DMA_ACTIVE stays high throughout.
REQ-024 SHALL keep index 8 bits wide; index never exceeds 159 and never wraps.
REQ-025 SHALL hold DMA_RD and OAM_WR low in IDLE and START; they are never high in the same cycle.

Reset
REQ-026 SHALL on rst force state=IDLE, FF46=0, index=0, and DMA_RD, OAM_WR, DMA_ACTIVE=0, DMA_ADDR=0, OAM_ADDR=0, OAM_DATA=0, independent of clk.
REQ-027 SHALL abandon a mid-transfer reset without completing further OAM writes; OAM contents already written are retained.

Configuration
REQ-028 SHALL provide macro OAM_DMA_CPU_BLOCK_EN.
REQ-029 SHALL with OAM_DMA_CPU_BLOCK_EN defined add output CPU_BLOCK (1 bit) = DMA_ACTIVE && !(ADDR>=16'hFF80 && ADDR<=16'hFFFE) && !(ADDR==16'hFF46), and drive MMIO_DATA_in=8'hFF whenever CPU_BLOCK is high.
REQ-030 SHALL without the macro omit CPU_BLOCK; CPU access is unrestricted and arbitration is left to the bus.

Verification
REQ-031 SHALL cover: write 8'hC0 to FF46, memory returns addr[7:0] -> 160 OAM writes, FE00..FE9F data 00..9F, DMA_ACTIVE high 321 clk.
REQ-032 SHALL cover: write 8'hE1 -> DMA_ADDR sequence 16'hC100..16'hC19F.
REQ-033 SHALL cover: write 8'hC0, then 8'hD0 at clk 100 of the transfer -> writes after restart read from 16'hD000 starting at OAM 16'hFE00; DMA_ACTIVE never drops.
REQ-034 SHALL cover: assert rst at clk 50 of a transfer -> all outputs 0 immediately; no OAM_WR afterwards; FF46 reads 8'h00.
REQ-035 SHALL cover: read ADDR=16'hFF46 after writing 8'h80 -> MMIO_DATA_in=8'h80; ADDR=16'hFF47 -> 8'hFF.
REQ-036 SHALL cover, with OAM_DMA_CPU_BLOCK_EN: during a transfer, ADDR=16'hFF85 -> CPU_BLOCK=0; ADDR=16'hC000 -> CPU_BLOCK=1, MMIO_DATA_in=8'hFF.
